// File: rtl/alu_seq_if.sv
// Request/result bundle between the EX-stage control and the sequential ALU.
// The master drives the operation request; the slave returns result, HI/LO and handshake.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             valid_i;
  logic [3:0]       alu_operation_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [SHW-1:0]   shamt_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] alu_data_o;
  logic             zero_o;
  logic             overflow_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output valid_i, alu_operation_i, a_i, b_i, shamt_i,
    input  ready_o, done_o, alu_data_o, zero_o, overflow_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, alu_operation_i, a_i, b_i, shamt_i,
    output ready_o, done_o, alu_data_o, zero_o, overflow_o, hi_o, lo_o
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle ops register on accept; MULT/DIV iterate WIDTH cycles into HI/LO.
// ready drops for the whole mul/div; requests while not ready are ignored and must be held by the requester.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             ready, accept, is_muldiv;

  logic [SHW-1:0]   cnt;
  logic             op_div, neg_lo, neg_hi, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo, a_save;

  logic [WIDTH-1:0] alu_data, hi, lo;
  logic             zero, overflow, done;

  assign op        = bus.alu_operation_i;
  assign a         = bus.a_i;
  assign b         = bus.b_i;
  assign is_muldiv = (op[3:2] == 2'b11);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.valid_i && is_muldiv) state_next = RUN;
      end
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept = ready & bus.valid_i;

  // ---------------- single-cycle result ----------------
  logic [WIDTH-1:0] add_r, sub_r, sc_res;
  logic             sc_ovf;

  assign add_r = a + b;
  assign sub_r = a - b;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (op)
      4'b0000: sc_res = a & b;
      4'b0001: begin
        sc_res = sub_r;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: sc_res = a | b;
      4'b0011: begin
        sc_res = add_r;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0100: sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b0101: sc_res = b << bus.shamt_i;
      4'b0110: sc_res = b >> bus.shamt_i;
      4'b0111: sc_res = $signed(b) >>> bus.shamt_i;
      4'b1000: sc_res = ~(a | b);
      4'b1001: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1010: sc_res = hi;
      4'b1011: sc_res = lo;
      default: sc_res = '0;
    endcase
  end

  // ---------------- mul/div operand preparation ----------------
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  // op[0] selects the signed variants (MULT, DIV)
  assign a_neg    = op[0] & a[WIDTH-1];
  assign b_neg    = op[0] & b[WIDTH-1];
  assign mag_a_in = a_neg ? -a : a;
  assign mag_b_in = b_neg ? -b : b;

  // ---------------- one iteration ----------------
  // Multiply: shift-add with multiplicand mag_a, multiplier shifting out of acc_lo.
  // Divide: restoring, remainder in acc_hi, dividend shifting out of acc_lo, quotient shifting in.
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   div_diff, step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;
  logic               div_ge;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
  assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, mag_b};
  assign div_diff = rem_sh[WIDTH-1:0] - mag_b;

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (op_div) begin
      step_hi = div_ge ? div_diff : rem_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  assign prod = {step_hi, step_lo};

  always_comb begin
    {fin_hi, fin_lo} = neg_lo ? -prod : prod;
    if (op_div) begin
      if (div_zero) begin
        fin_lo = '1;
        fin_hi = a_save;
      end else begin
        // Most-negative / -1 wraps naturally: magnitude 2^(W-1) negates to itself.
        fin_lo = neg_lo ? -step_lo : step_lo;
        fin_hi = neg_hi ? -step_hi : step_hi;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      a_save   <= '0;
      alu_data <= '0;
      hi       <= '0;
      lo       <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_muldiv) begin
              cnt      <= '0;
              op_div   <= op[1];
              neg_lo   <= a_neg ^ b_neg;
              neg_hi   <= a_neg;
              div_zero <= (b == '0);
              mag_a    <= mag_a_in;
              mag_b    <= mag_b_in;
              acc_hi   <= '0;
              acc_lo   <= op[1] ? mag_a_in : mag_b_in;
              a_save   <= a;
            end else begin
              alu_data <= sc_res;
              zero     <= (sc_res == '0);
              overflow <= sc_ovf;
              done     <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi       <= fin_hi;
            lo       <= fin_lo;
            alu_data <= fin_lo;
            zero     <= (fin_lo == '0);
            overflow <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o    = ready;
  assign bus.done_o     = done;
  assign bus.alu_data_o = alu_data;
  assign bus.zero_o     = zero;
  assign bus.overflow_o = overflow;
  assign bus.hi_o       = hi;
  assign bus.lo_o       = lo;
endmodule
